// File: rtl/seg_pkg.sv
// Shared seven-segment types, the active-low glyph table and the nibble decoder,
// used by any block that drives a common-anode digit.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 first in the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nibble, input logic hex_mode);
        if (!hex_mode && (nibble > 4'd9))
            return SEG_TABLE[0];
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-glyph decoder; HEX_MODE=0 shows 10..15 as "0".
module seg_decode
    import seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b1
) (
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i, HEX_MODE);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display driver: shadow registers, prescaled digit
// scan, guard blanking at each slot start, and fully registered pin outputs.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int PRESCALE         = 50000,
    parameter int GUARD            = 2,
    parameter bit HEX_MODE         = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    localparam int SEL_W           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  displayWrite,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [6:0]            output_,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     anode,
    output logic [SEL_W-1:0]      digit_sel
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [DIGITS-1:0][3:0]   data_q;
    logic [DIGITS-1:0]        dp_q, blank_q;
    seg_t                     seg_q, seg_d;
    logic                     dpo_q, dpo_d;
    logic [DIGITS-1:0]        an_q, an_d;

    logic       pcnt_last;
    logic       in_guard;
    logic [3:0] cur_nib;
    logic       cur_dp, cur_blank;
    seg_t       cur_seg;

    assign pcnt_last = (pcnt_q == PCNT_W'(PRESCALE - 1));

    always_comb begin
        pcnt_d = pcnt_last ? '0 : pcnt_q + 1'b1;
        sel_d  = sel_q;
        if (pcnt_last)
            sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
    end

    generate
        if (DIGITS == 1) begin : g_single
            assign cur_nib   = data_q[0];
            assign cur_dp    = dp_q[0];
            assign cur_blank = blank_q[0];
        end else begin : g_multi
            assign cur_nib   = data_q[sel_q];
            assign cur_dp    = dp_q[sel_q];
            assign cur_blank = blank_q[sel_q];
        end

        if (GUARD == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (pcnt_q < PCNT_W'(GUARD));
        end
    endgenerate

    seg_decode #(.HEX_MODE(HEX_MODE)) u_dec (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    // Segments and anodes are registered together so they can never skew apart.
    always_comb begin
        seg_d = cur_blank ? SEG_OFF : cur_seg;
        dpo_d = cur_blank | ~cur_dp;
        an_d  = in_guard ? '0 : (DIGITS'(1) << sel_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            seg_q   <= SEG_OFF;
            dpo_q   <= 1'b1;
            an_q    <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            sel_q  <= sel_d;
            if (displayWrite) begin
                data_q  <= data_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
            end
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end

    // an_q is kept active-high internally; polarity is applied only at the pin.
    assign anode     = ANODE_ACTIVE_LOW ? ~an_q : an_q;
    assign output_   = seg_q;
    assign dp_out    = dpo_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench: three configurations (4-digit hex, 4-digit BCD, 1-digit no-guard)
// checked every cycle against a slot/phase arithmetic model of the display.
module tb_seven_seg_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        we;
    logic [15:0] din;
    logic [3:0]  dpin, blin;
    logic        we_c;
    logic [3:0]  din_c;
    logic        dpin_c, blin_c;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b;
    logic       an_c;
    logic [1:0] sel_a, sel_b;
    logic       sel_c;

    seven_seg_scan #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .HEX_MODE(1'b1), .ANODE_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .displayWrite(we), .data_in(din), .dp_in(dpin), .blank_in(blin),
        .output_(seg_a), .dp_out(dp_a), .anode(an_a), .digit_sel(sel_a));

    seven_seg_scan #(.DIGITS(4), .PRESCALE(8), .GUARD(2), .HEX_MODE(1'b0), .ANODE_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .displayWrite(we), .data_in(din), .dp_in(dpin), .blank_in(blin),
        .output_(seg_b), .dp_out(dp_b), .anode(an_b), .digit_sel(sel_b));

    seven_seg_scan #(.DIGITS(1), .PRESCALE(3), .GUARD(0), .HEX_MODE(1'b1), .ANODE_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .displayWrite(we_c), .data_in(din_c), .dp_in(dpin_c), .blank_in(blin_c),
        .output_(seg_c), .dp_out(dp_c), .anode(an_c), .digit_sel(sel_c));

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] sel;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    int errors = 0;
    int checks = 0;

    logic [6:0] TBL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model state: shadow contents and edges since reset release.
    logic [3:0] sh_d [4];
    logic [3:0] sh_dp, sh_bl;
    logic [3:0] shc_d;
    logic       shc_dp, shc_bl;
    int         m;

    function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit hex);
        if (!hex && v > 4'd9) return 7'b1000000;
        return TBL[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        exp_t ea, eb, ec;
        int s, pc;
        @(posedge clk);
        if (!rst_n) begin
            ea.seg = 7'h7F; ea.dp = 1'b1; ea.an = 4'hF; ea.sel = 2'd0;
            eb = ea;
            ec.seg = 7'h7F; ec.dp = 1'b1; ec.an = 4'h1; ec.sel = 2'd0;
            for (int i = 0; i < 4; i++) sh_d[i] = 4'h0;
            sh_dp = 4'h0; sh_bl = 4'h0;
            shc_d = 4'h0; shc_dp = 1'b0; shc_bl = 1'b0;
            m = 0;
        end else begin
            s  = (m / 8) % 4;
            pc = m % 8;
            ea.seg = sh_bl[s] ? 7'h7F : ref_seg(sh_d[s], 1'b1);
            eb.seg = sh_bl[s] ? 7'h7F : ref_seg(sh_d[s], 1'b0);
            ea.dp  = sh_bl[s] | ~sh_dp[s];
            ea.an  = (pc < 2) ? 4'hF : ~(4'b0001 << s);
            ea.sel = 2'(((m + 1) / 8) % 4);
            eb.dp = ea.dp; eb.an = ea.an; eb.sel = ea.sel;
            ec.seg = shc_bl ? 7'h7F : ref_seg(shc_d, 1'b1);
            ec.dp  = shc_bl | ~shc_dp;
            ec.an  = 4'h0;
            ec.sel = 2'd0;
            if (we) begin
                for (int i = 0; i < 4; i++) sh_d[i] = din[4*i +: 4];
                sh_dp = dpin; sh_bl = blin;
            end
            if (we_c) begin
                shc_d = din_c; shc_dp = dpin_c; shc_bl = blin_c;
            end
            m++;
        end
        qa.push_back(ea);
        qb.push_back(eb);
        qc.push_back(ec);
        #2;
        we_c   = ($urandom_range(0, 1) == 1);
        din_c  = 4'($urandom);
        dpin_c = 1'($urandom);
        blin_c = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("seg_a", 32'(seg_a), 32'(e.seg));
                chk("dp_a",  32'(dp_a),  32'(e.dp));
                chk("an_a",  32'(an_a),  32'(e.an));
                chk("sel_a", 32'(sel_a), 32'(e.sel));
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("seg_b", 32'(seg_b), 32'(e.seg));
                chk("dp_b",  32'(dp_b),  32'(e.dp));
                chk("an_b",  32'(an_b),  32'(e.an));
                chk("sel_b", 32'(sel_b), 32'(e.sel));
            end
            if (qc.size() > 0) begin
                e = qc.pop_front();
                chk("seg_c", 32'(seg_c), 32'(e.seg));
                chk("dp_c",  32'(dp_c),  32'(e.dp));
                chk("an_c",  32'(an_c),  32'(e.an[0]));
                chk("sel_c", 32'(sel_c), 32'(e.sel[0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; we = 1'b1; din = 16'h1234; dpin = 4'hF; blin = 4'h0;
        we_c = 1'b1; din_c = 4'h5; dpin_c = 1'b1; blin_c = 1'b0;
        m = 0;
        repeat (3) tick();

        rst_n = 1'b1; we = 1'b0;
        repeat (2) tick();

        // Scan order with 4321, no blanks or points.
        we = 1'b1; din = 16'h4321; dpin = 4'h0; blin = 4'h0;
        tick();
        we = 1'b0;
        repeat (34) tick();

        // Nibble A on digit 0: hex glyph on dut_a, "0" on dut_b.
        we = 1'b1; din = 16'h432A;
        tick();
        we = 1'b0;
        repeat (34) tick();

        // Blank digit 1, decimal points on digits 0 and 2.
        we = 1'b1; din = 16'h4321; dpin = 4'b0101; blin = 4'b0010;
        tick();
        we = 1'b0;
        repeat (34) tick();

        // Write landing on the edge where the scan moves from slot 1 to slot 2.
        while (m % 32 != 15) tick();
        we = 1'b1; din = 16'h4821; dpin = 4'h0; blin = 4'h0;
        tick();
        we = 1'b0;
        repeat (20) tick();

        repeat (400) begin
            we   = ($urandom_range(0, 7) == 0);
            din  = 16'($urandom);
            dpin = 4'($urandom);
            blin = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        rst_n = 1'b0; we = 1'b1; din = 16'hFFFF;
        repeat (2) tick();
        rst_n = 1'b1; we = 1'b0;

        repeat (150) begin
            we   = ($urandom_range(0, 5) == 0);
            din  = 16'($urandom);
            dpin = 4'($urandom);
            blin = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drain", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed nibble word on a write strobe and cycles through the digits with a prescaled scan counter. Each digit is decoded to active-low segments, with a guard interval that suppresses ghosting when the scan moves to the next digit. It sits between the datapath/controller and the board display pins, replacing per-digit single-decoder instances.

## Interface
- DIGITS, 4: number of multiplexed digits; ≥1.
- PRESCALE, 50000: clk cycles per digit slot; ≥ GUARD+1.
- GUARD, 2: cycles at the start of each slot with all anodes inactive; ≥0.
- HEX_MODE, 1: 1 decodes A–F; 0 decodes 10–15 as "0" (legacy BCD behaviour).
- ANODE_ACTIVE_LOW, 1: polarity of the anode outputs.

Ports:
- clk  in  1: single clock. All logic is on the rising edge.
- rst_n  in  1: synchronous, active-low reset.
- displayWrite  in  1: when high at a clk edge, the shadow registers load data_in, dp_in and blank_in.
- data_in  in  4*DIGITS: nibble i is digit i, in bits [4i+3:4i].
- dp_in  in  DIGITS: decimal point request per digit, active-high.
- blank_in  in  DIGITS: blank request per digit, active-high.
- output_  out  7: segments {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1: decimal point, active-low.
- anode  out  DIGITS: one-hot digit enable, polarity set by ANODE_ACTIVE_LOW.
- digit_sel  out  max(1,$clog2(DIGITS)): index of the current slot.

## Operation
- Shadow registers hold data, dp and blank. They load only on displayWrite and hold otherwise. They are independent of the scan, so a write mid-slot is allowed.
- Prescaler pcnt counts 0..PRESCALE-1 and wraps.
  - When pcnt = PRESCALE-1, digit_sel advances.
  - digit_sel wraps DIGITS-1 → 0.
  - With DIGITS=1, digit_sel stays at 0.
- Output stage is registered every cycle from the current digit_sel and the shadow values:
  - output_ = decode(data[digit_sel]), or 7'h7F if blank[digit_sel].
  - dp_out = ~dp[digit_sel], forced to 1 if blanked.
  - anode = one-hot(digit_sel), all inactive while pcnt < GUARD.
- Decode table (active-low):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000
  - A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110
  - With HEX_MODE=0, values 10–15 decode to 1000000.
- Reset state (rst_n low at an edge):
  - pcnt=0, digit_sel=0.
  - Shadow data=0, dp=0, blank=0.
  - output_=7'h7F, dp_out=1, all anodes inactive.
- Reset takes priority over displayWrite on the same edge.
- Releasing reset restarts the scan at digit 0, pcnt 0.

## Timing
- Write latency: displayWrite sampled at edge t updates the shadow at t. The new value reaches output_ at edge t+1 if digit_sel addresses that digit.
- Slot boundary:
  - The edge with pcnt=PRESCALE-1 advances digit_sel.
  - The following edge registers the new digit's segments with anodes inactive, provided GUARD≥1.
  - Anodes go active GUARD cycles later.
- With GUARD=0, segments and anode change on the same edge. Both are registered together, so they are never skewed by a cycle.
- Full scan period = DIGITS*PRESCALE cycles. Each digit has PRESCALE-GUARD active cycles.
- A write and a slot change on the same edge produce no glitch. The output reflects the post-write shadow of the new digit.

## Structure
- Package seg_pkg holds:
  - SEG_OFF = 7'h7F.
  - The 16-entry decode constant table.
  - A seg_t 7-bit typedef.
  - Function hex_to_seg(nibble, hex_mode).
- Sub-module seg_decode: combinational nibble → seg_t wrapper around hex_to_seg. It is instantiated once and fed by the shadow mux, and is reusable by other display blocks.
- Top level holds the shadow registers, prescaler, digit counter, guard compare and output registers.

## Test plan
- Reset: hold rst_n low 3 cycles with displayWrite=1 and data_in=16'h1234. Required: output_=7'h7F, dp_out=1, anode=4'b1111, shadow still 0 after release.
- Scan order (DIGITS=4, PRESCALE=8, GUARD=2): write 16'h4321.
  - digit_sel goes 0,1,2,3,0 every 8 cycles.
  - output_ shows 1111001, 0100100, 0110000, 0011001 on slots 0–3.
  - anode is low on bits 0–3 in turn, only for pcnt 2..7.
- Hex vs BCD: write nibble 4'hA to digit 0.
  - HEX_MODE=1 → 0001000.
  - HEX_MODE=0 → 1000000.
- Blank/dp: blank_in=4'b0010, dp_in=4'b0101.
  - Slot 1 → output_=7'h7F, dp_out=1.
  - Slots 0 and 2 → dp_out=0.
  - Slot 3 → dp_out=1.
- Write at slot boundary: displayWrite on the same edge digit_sel advances to 2, changing nibble 2 from 3 to 8. Required: the first registered value for slot 2 is 0000000, with no cycle of 0110000.
- DIGITS=1, GUARD=0: digit_sel stays 0, anode is constantly active, and output_ tracks each write one cycle later.
